lc3_decode: RTL and testbench
=============================

# lc3_decode

Instruction-decode stage of the LC3 core, directly downstream of `fetch`. After `fetch` presents `addr_out` to instruction memory and the controller pulses `decode_start`, this block waits out the memory read latency and latches the returned word into the instruction register (IR). It splits the IR into the opcode, register-select, immediate, offset and condition fields that `fetch` (`opCode_in`, `offset_in`, `br_nzp`) and the execute stage consume, and raises a one-cycle `decode_done`.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from `decode_start` to valid `mem_dout`; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `decode_start`  in  1  one-cycle request; `fetch` is driving the instruction address in this cycle.
- `pc_in`  in  16  `fetch` `pc` value, captured with `decode_start`.
- `mem_dout`  in  16  instruction memory read data.
- `busy`  out  1  high in every non-IDLE state.
- `decode_done`  out  1  one-cycle pulse; all field outputs are valid from this cycle on.
- `ir`  out  16  latched instruction.
- `pc_out`  out  16  PC captured with the request.
- `opCode_out`  out  4  IR[15:12].
- `dr`  out  3  IR[11:9]; destination, or store source for ST/STI/STR.
- `br_nzp`  out  3  IR[11:9]; branch condition mask.
- `sr1`  out  3  IR[8:6]; SR1 or BaseR.
- `sr2`  out  3  IR[2:0].
- `imm_flag`  out  1  IR[5].
- `imm5_sext`  out  16  IR[4:0] sign-extended.
- `offset6_sext`  out  16  IR[5:0] sign-extended.
- `offset9`  out  9  IR[8:0] raw; feeds `fetch` `offset_in`.
- `offset9_sext`  out  16  IR[8:0] sign-extended.
- `offset11_sext`  out  16  IR[10:0] sign-extended.
- `jsr_flag`  out  1  IR[11]; 1 = JSR, 0 = JSRR.
- `trapvect8`  out  16  IR[7:0] zero-extended.
- `reg_we`  out  1  1 when the opcode writes the register file: ADD, AND, NOT, LD, LDI, LDR, LEA.
- `illegal`  out  1  1 for opcode 1101 (reserved) and 1000 (RTI; privilege modes are not supported).

## Operation
- FSM states:
  - IDLE: `decode_start` captures `pc_in`, loads the wait counter with `MEM_LATENCY`, and moves to WAIT.
  - WAIT: the counter decrements each cycle. The cycle in which it reaches 0 samples `mem_dout` into `ir` and moves to DONE.
  - DONE: `decode_done` = 1 for exactly one cycle, then back to IDLE.
- All field outputs are combinational slices of the registered `ir`. They are stable from `decode_done` until the next IR capture.
- `reg_we` and `illegal` are also decoded from `ir`.
- `decode_start` in WAIT or DONE is ignored: no queueing, and `pc_out` is not updated.
- `decode_start` in IDLE on the cycle after DONE is accepted normally, giving back-to-back decodes.
- Sign extension replicates the field MSB up to bit 15. `trapvect8` zero-fills bits 15:8.
- `illegal` does not block `decode_done`; the controller handles the exception.

## Timing
- `decode_start` sampled at edge T. `ir` is loaded at edge T+`MEM_LATENCY`. `decode_done` is high in the cycle following that edge.
- Request-to-done latency = `MEM_LATENCY`+1 cycles. With the default, the minimum request spacing is 3 cycles.
- Reset values: `ir` = 0, `pc_out` = 0, `busy` = 0, `decode_done` = 0, state IDLE.
- Because `ir` resets to 0x0000, every field output reads 0 after reset and `reg_we` = 0 (BR with empty mask).
- Reset asserted mid-WAIT or in DONE: at the next edge the block returns to IDLE with all registers cleared. No `decode_done` is issued for the aborted request.
- `rst` and `decode_start` high in the same cycle: reset wins and the request is dropped.

## Structure
- Shared `lc3_pkg` holds:
  - the 16 opcode localparams (OP_BR = 4'b0000 … OP_TRAP = 4'b1111);
  - the width constants WORD_W = 16 and REG_SEL_W = 3;
  - the FSM state encoding, also used by the controller's monitors.
- One sub-module, `lc3_field_extract`: purely combinational, maps `ir` to all field outputs, `reg_we` and `illegal`, so the execute stage can reuse it.
- The top holds only the FSM, the counter, `ir` and `pc_out`.

## Test plan
- ADD R1,R2,#-3: `mem_dout` = 0x12BD, `MEM_LATENCY` = 1, `pc_in` = 0x3000.
  → `decode_done` 2 cycles after the request; `dr` = 1, `sr1` = 2, `imm_flag` = 1, `imm5_sext` = 0xFFFD, `reg_we` = 1, `pc_out` = 0x3000.
- BRnzp #-1: 0x0FFF → `opCode_out` = 0, `br_nzp` = 3'b111, `offset9` = 0x1FF, `offset9_sext` = 0xFFFF, `reg_we` = 0.
- LD R3,#5 (0x2605) then TRAP x25 (0xF025), back-to-back with `MEM_LATENCY` = 3:
  - first `decode_done` at request+4: `dr` = 3, `offset9_sext` = 0x0005;
  - second: `trapvect8` = 0x0025;
  - a `decode_start` pulsed during WAIT is ignored.
- Reserved 0xD000 → `illegal` = 1 and `decode_done` still pulses. RTI 0x8000 → `illegal` = 1.
- `rst` asserted in the WAIT cycle → no `decode_done` ever appears; `ir` = 0, `busy` = 0, `pc_out` = 0 on the next cycle.
- After 5 reset cycles with no request → all outputs 0, `busy` = 0, `decode_done` stays 0 for 20 cycles.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcodes, datapath widths and the decode FSM encoding.
package lc3_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned REG_SEL_W = 3;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } decode_state_e;

endpackage

// File: rtl/lc3_decode_if.sv
// Decode-stage bus: request/memory inputs from fetch, IR fields out to fetch and execute.
interface lc3_decode_if;
  import lc3_pkg::*;

  logic                 decode_start;
  logic [WORD_W-1:0]    pc_in;
  logic [WORD_W-1:0]    mem_dout;
  logic                 busy;
  logic                 decode_done;
  logic [WORD_W-1:0]    ir;
  logic [WORD_W-1:0]    pc_out;
  logic [3:0]           opCode_out;
  logic [REG_SEL_W-1:0] dr;
  logic [REG_SEL_W-1:0] br_nzp;
  logic [REG_SEL_W-1:0] sr1;
  logic [REG_SEL_W-1:0] sr2;
  logic                 imm_flag;
  logic [WORD_W-1:0]    imm5_sext;
  logic [WORD_W-1:0]    offset6_sext;
  logic [8:0]           offset9;
  logic [WORD_W-1:0]    offset9_sext;
  logic [WORD_W-1:0]    offset11_sext;
  logic                 jsr_flag;
  logic [WORD_W-1:0]    trapvect8;
  logic                 reg_we;
  logic                 illegal;

  modport master (
    output decode_start, pc_in, mem_dout,
    input  busy, decode_done, ir, pc_out, opCode_out, dr, br_nzp, sr1, sr2, imm_flag,
           imm5_sext, offset6_sext, offset9, offset9_sext, offset11_sext, jsr_flag,
           trapvect8, reg_we, illegal
  );

  modport slave (
    input  decode_start, pc_in, mem_dout,
    output busy, decode_done, ir, pc_out, opCode_out, dr, br_nzp, sr1, sr2, imm_flag,
           imm5_sext, offset6_sext, offset9, offset9_sext, offset11_sext, jsr_flag,
           trapvect8, reg_we, illegal
  );

endinterface

// File: rtl/lc3_field_extract.sv
// Combinational IR field splitter, shared by decode and execute.
module lc3_field_extract
  import lc3_pkg::*;
(
  input  logic [WORD_W-1:0]    i_ir,
  output logic [3:0]           o_opcode,
  output logic [REG_SEL_W-1:0] o_dr,
  output logic [REG_SEL_W-1:0] o_br_nzp,
  output logic [REG_SEL_W-1:0] o_sr1,
  output logic [REG_SEL_W-1:0] o_sr2,
  output logic                 o_imm_flag,
  output logic [WORD_W-1:0]    o_imm5_sext,
  output logic [WORD_W-1:0]    o_offset6_sext,
  output logic [8:0]           o_offset9,
  output logic [WORD_W-1:0]    o_offset9_sext,
  output logic [WORD_W-1:0]    o_offset11_sext,
  output logic                 o_jsr_flag,
  output logic [WORD_W-1:0]    o_trapvect8,
  output logic                 o_reg_we,
  output logic                 o_illegal
);

  assign o_opcode        = i_ir[15:12];
  assign o_dr            = i_ir[11:9];
  assign o_br_nzp        = i_ir[11:9];
  assign o_sr1           = i_ir[8:6];
  assign o_sr2           = i_ir[2:0];
  assign o_imm_flag      = i_ir[5];
  assign o_imm5_sext     = {{11{i_ir[4]}}, i_ir[4:0]};
  assign o_offset6_sext  = {{10{i_ir[5]}}, i_ir[5:0]};
  assign o_offset9       = i_ir[8:0];
  assign o_offset9_sext  = {{7{i_ir[8]}}, i_ir[8:0]};
  assign o_offset11_sext = {{5{i_ir[10]}}, i_ir[10:0]};
  assign o_jsr_flag      = i_ir[11];
  assign o_trapvect8     = {8'h00, i_ir[7:0]};

  always_comb begin
    o_reg_we  = 1'b0;
    o_illegal = 1'b0;
    case (i_ir[15:12])
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR, OP_LEA: o_reg_we = 1'b1;
      OP_RES, OP_RTI: o_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: waits out instruction-memory latency, latches IR and PC, pulses done.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  lc3_decode_if.slave  bus
);

  localparam logic [2:0] LatInit = 3'(MEM_LATENCY);

  decode_state_e     r_state, w_state_next;
  logic [2:0]        r_cnt, w_cnt_next;
  logic [WORD_W-1:0] r_ir, w_ir_next;
  logic [WORD_W-1:0] r_pc, w_pc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
      r_ir    <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ir    <= w_ir_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ir_next    = r_ir;
    w_pc_next    = r_pc;
    case (r_state)
      StIdle: begin
        if (bus.decode_start) begin
          w_pc_next    = bus.pc_in;
          w_cnt_next   = LatInit;
          w_state_next = StWait;
        end
      end
      StWait: begin
        w_cnt_next = r_cnt - 3'd1;
        // Counter hits zero on this edge: memory data is valid now.
        if (r_cnt == 3'd1) begin
          w_ir_next    = bus.mem_dout;
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign bus.busy        = (r_state != StIdle);
  assign bus.decode_done = (r_state == StDone);
  assign bus.ir          = r_ir;
  assign bus.pc_out      = r_pc;

  lc3_field_extract u_field_extract (
    .i_ir            (r_ir),
    .o_opcode        (bus.opCode_out),
    .o_dr            (bus.dr),
    .o_br_nzp        (bus.br_nzp),
    .o_sr1           (bus.sr1),
    .o_sr2           (bus.sr2),
    .o_imm_flag      (bus.imm_flag),
    .o_imm5_sext     (bus.imm5_sext),
    .o_offset6_sext  (bus.offset6_sext),
    .o_offset9       (bus.offset9),
    .o_offset9_sext  (bus.offset9_sext),
    .o_offset11_sext (bus.offset11_sext),
    .o_jsr_flag      (bus.jsr_flag),
    .o_trapvect8     (bus.trapvect8),
    .o_reg_we        (bus.reg_we),
    .o_illegal       (bus.illegal)
  );

endmodule

// File: tb/tb_lc3_decode.sv
// Bench for lc3_decode at MEM_LATENCY 1 and 3: vector table, scoreboard and reset corner cases.
module tb_lc3_decode;
  import lc3_pkg::*;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        we;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t q1[$];
  vec_t q3[$];
  vec_t tbl[17];

  always #5 clk = ~clk;

  lc3_decode_if b1 ();
  lc3_decode_if b3 ();

  lc3_decode #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  lc3_decode #(.MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Independent arithmetic model of the field slicing.
  function automatic int fld(logic [15:0] w, int lo, int n);
    return (int'(w) >> lo) % (1 << n);
  endfunction

  function automatic logic [15:0] sx(int v, int n);
    int s;
    s = (v >= (1 << (n - 1))) ? v - (1 << n) : v;
    return 16'(s);
  endfunction

  task automatic check_out(string tag, vec_t e, logic [15:0] ir, logic [15:0] pc,
                           logic [3:0] op, logic [2:0] dr, logic [2:0] nzp, logic [2:0] s1,
                           logic [2:0] s2, logic imm, logic [15:0] i5, logic [15:0] o6,
                           logic [8:0] o9, logic [15:0] o9s, logic [15:0] o11, logic jsr,
                           logic [15:0] tv, logic we, logic ill);
    chk({tag, ".ir"}, ir, e.instr);
    chk({tag, ".pc_out"}, pc, e.pc);
    chk({tag, ".opcode"}, 16'(op), 16'(fld(e.instr, 12, 4)));
    chk({tag, ".dr"}, 16'(dr), 16'(fld(e.instr, 9, 3)));
    chk({tag, ".br_nzp"}, 16'(nzp), 16'(fld(e.instr, 9, 3)));
    chk({tag, ".sr1"}, 16'(s1), 16'(fld(e.instr, 6, 3)));
    chk({tag, ".sr2"}, 16'(s2), 16'(fld(e.instr, 0, 3)));
    chk({tag, ".imm_flag"}, 16'(imm), 16'(fld(e.instr, 5, 1)));
    chk({tag, ".imm5_sext"}, i5, sx(fld(e.instr, 0, 5), 5));
    chk({tag, ".offset6_sext"}, o6, sx(fld(e.instr, 0, 6), 6));
    chk({tag, ".offset9"}, 16'(o9), 16'(fld(e.instr, 0, 9)));
    chk({tag, ".offset9_sext"}, o9s, sx(fld(e.instr, 0, 9), 9));
    chk({tag, ".offset11_sext"}, o11, sx(fld(e.instr, 0, 11), 11));
    chk({tag, ".jsr_flag"}, 16'(jsr), 16'(fld(e.instr, 11, 1)));
    chk({tag, ".trapvect8"}, tv, 16'(fld(e.instr, 0, 8)));
    chk({tag, ".reg_we"}, 16'(we), 16'(e.we));
    chk({tag, ".illegal"}, 16'(ill), 16'(e.ill));
  endtask

  always @(negedge clk) begin
    if (b1.decode_done) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL dut1.spurious_done: got decode_done=1 expected 0 (no pending request)");
      end else begin
        vec_t e;
        e = q1.pop_front();
        check_out("dut1", e, b1.ir, b1.pc_out, b1.opCode_out, b1.dr, b1.br_nzp, b1.sr1,
                  b1.sr2, b1.imm_flag, b1.imm5_sext, b1.offset6_sext, b1.offset9,
                  b1.offset9_sext, b1.offset11_sext, b1.jsr_flag, b1.trapvect8, b1.reg_we,
                  b1.illegal);
      end
    end
  end

  always @(negedge clk) begin
    if (b3.decode_done) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_bad++;
        $display("FAIL dut3.spurious_done: got decode_done=1 expected 0 (no pending request)");
      end else begin
        vec_t e;
        e = q3.pop_front();
        check_out("dut3", e, b3.ir, b3.pc_out, b3.opCode_out, b3.dr, b3.br_nzp, b3.sr1,
                  b3.sr2, b3.imm_flag, b3.imm5_sext, b3.offset6_sext, b3.offset9,
                  b3.offset9_sext, b3.offset11_sext, b3.jsr_flag, b3.trapvect8, b3.reg_we,
                  b3.illegal);
      end
    end
  end

  // Issue one request on the latency-1 DUT from a negedge; returns one cycle after done.
  task automatic req1(vec_t v);
    int k;
    q1.push_back(v);
    b1.decode_start = 1'b1;
    b1.pc_in        = v.pc;
    b1.mem_dout     = v.instr;
    @(negedge clk);
    b1.decode_start = 1'b0;
    k = 1;
    while (!b1.decode_done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("dut1.latency", 16'(k), 16'd2);
    @(negedge clk);
    chk("dut1.done_pulse", 16'(b1.decode_done), 16'd0);
    chk("dut1.busy_after", 16'(b1.busy), 16'd0);
  endtask

  task automatic wait_done3(output int k);
    k = 1;
    while (!b3.decode_done && k < 12) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int dones;
    vec_t v;

    tbl[0]  = '{16'h12BD, 16'h3000, 1'b1, 1'b0};  // ADD R1,R2,#-3
    tbl[1]  = '{16'h0FFF, 16'h3001, 1'b0, 1'b0};  // BRnzp #-1
    tbl[2]  = '{16'h2605, 16'h3002, 1'b1, 1'b0};  // LD
    tbl[3]  = '{16'h3A3F, 16'h3003, 1'b0, 1'b0};  // ST
    tbl[4]  = '{16'h4FFF, 16'h3004, 1'b0, 1'b0};  // JSR
    tbl[5]  = '{16'h4080, 16'h3005, 1'b0, 1'b0};  // JSRR
    tbl[6]  = '{16'h5B61, 16'h3006, 1'b1, 1'b0};  // AND
    tbl[7]  = '{16'h6C7F, 16'h3007, 1'b1, 1'b0};  // LDR
    tbl[8]  = '{16'h7E00, 16'h3008, 1'b0, 1'b0};  // STR
    tbl[9]  = '{16'h8000, 16'h3009, 1'b0, 1'b1};  // RTI
    tbl[10] = '{16'h967F, 16'h300A, 1'b1, 1'b0};  // NOT
    tbl[11] = '{16'hA5FF, 16'h300B, 1'b1, 1'b0};  // LDI
    tbl[12] = '{16'hB7F0, 16'h300C, 1'b0, 1'b0};  // STI
    tbl[13] = '{16'hC1C0, 16'h300D, 1'b0, 1'b0};  // JMP
    tbl[14] = '{16'hD000, 16'h300E, 1'b0, 1'b1};  // reserved
    tbl[15] = '{16'hE3F0, 16'h300F, 1'b1, 1'b0};  // LEA
    tbl[16] = '{16'hF025, 16'h3010, 1'b0, 1'b0};  // TRAP x25

    b1.decode_start = 1'b0; b1.pc_in = '0; b1.mem_dout = '0;
    b3.decode_start = 1'b0; b3.pc_in = '0; b3.mem_dout = '0;

    // Reset state and idle quiet period.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("rst.ir", b1.ir, 16'h0000);
    chk("rst.pc_out", b1.pc_out, 16'h0000);
    chk("rst.busy", 16'(b1.busy), 16'd0);
    chk("rst.opcode", 16'(b1.opCode_out), 16'd0);
    chk("rst.dr", 16'(b1.dr), 16'd0);
    chk("rst.sr1", 16'(b1.sr1), 16'd0);
    chk("rst.imm5_sext", b1.imm5_sext, 16'h0000);
    chk("rst.offset11_sext", b1.offset11_sext, 16'h0000);
    chk("rst.trapvect8", b1.trapvect8, 16'h0000);
    chk("rst.reg_we", 16'(b1.reg_we), 16'd0);
    chk("rst.illegal", 16'(b1.illegal), 16'd0);
    chk("rst.dut3_busy", 16'(b3.busy), 16'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (b1.decode_done || b3.decode_done) dones++;
    end
    chk("idle.done_count", 16'(dones), 16'd0);

    // Table sweep, back-to-back at minimum spacing.
    foreach (tbl[i]) req1(tbl[i]);

    // Explicit expectations for the headline instructions.
    req1(tbl[0]);
    chk("add.dr", 16'(b1.dr), 16'd1);
    chk("add.sr1", 16'(b1.sr1), 16'd2);
    chk("add.imm_flag", 16'(b1.imm_flag), 16'd1);
    chk("add.imm5_sext", b1.imm5_sext, 16'hFFFD);
    chk("add.reg_we", 16'(b1.reg_we), 16'd1);
    chk("add.pc_out", b1.pc_out, 16'h3000);
    req1(tbl[1]);
    chk("br.opcode", 16'(b1.opCode_out), 16'd0);
    chk("br.nzp", 16'(b1.br_nzp), 16'd7);
    chk("br.offset9", 16'(b1.offset9), 16'h01FF);
    chk("br.offset9_sext", b1.offset9_sext, 16'hFFFF);
    chk("br.reg_we", 16'(b1.reg_we), 16'd0);
    req1(tbl[14]);
    chk("res.illegal", 16'(b1.illegal), 16'd1);
    req1(tbl[9]);
    chk("rti.illegal", 16'(b1.illegal), 16'd1);

    // Latency 3: LD then TRAP, with a stray request during WAIT.
    v = '{16'h2605, 16'h4000, 1'b1, 1'b0};
    q3.push_back(v);
    b3.decode_start = 1'b1; b3.pc_in = 16'h4000; b3.mem_dout = 16'h2605;
    @(negedge clk);
    b3.decode_start = 1'b0;
    @(negedge clk);
    b3.decode_start = 1'b1; b3.pc_in = 16'h5555;
    @(negedge clk);
    b3.decode_start = 1'b0; b3.pc_in = 16'h0000;
    k = 3;
    while (!b3.decode_done && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("ld.latency", 16'(k), 16'd4);
    chk("ld.dr", 16'(b3.dr), 16'd3);
    chk("ld.offset9_sext", b3.offset9_sext, 16'h0005);
    chk("ld.pc_out", b3.pc_out, 16'h4000);
    b3.mem_dout = 16'hF025;
    @(negedge clk);
    v = '{16'hF025, 16'h4010, 1'b0, 1'b0};
    q3.push_back(v);
    b3.decode_start = 1'b1; b3.pc_in = 16'h4010;
    @(negedge clk);
    b3.decode_start = 1'b0;
    wait_done3(k);
    chk("trap.latency", 16'(k), 16'd4);
    chk("trap.trapvect8", b3.trapvect8, 16'h0025);
    chk("trap.pc_out", b3.pc_out, 16'h4010);
    @(negedge clk);

    // Reset during WAIT aborts the request on both DUTs.
    b1.decode_start = 1'b1; b1.pc_in = 16'h7777; b1.mem_dout = 16'h1234;
    b3.decode_start = 1'b1; b3.pc_in = 16'h7777; b3.mem_dout = 16'h1234;
    @(negedge clk);
    b1.decode_start = 1'b0; b3.decode_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort1.ir", b1.ir, 16'h0000);
    chk("abort1.busy", 16'(b1.busy), 16'd0);
    chk("abort1.pc_out", b1.pc_out, 16'h0000);
    chk("abort3.ir", b3.ir, 16'h0000);
    chk("abort3.busy", 16'(b3.busy), 16'd0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (b1.decode_done || b3.decode_done) dones++;
    end
    chk("abort.done_count", 16'(dones), 16'd0);

    // Reset and request in the same cycle: reset wins.
    rst = 1'b1;
    b1.decode_start = 1'b1; b1.pc_in = 16'h9999;
    @(negedge clk);
    rst = 1'b0;
    b1.decode_start = 1'b0;
    chk("rst_start.busy", 16'(b1.busy), 16'd0);
    chk("rst_start.pc_out", b1.pc_out, 16'h0000);
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (b1.decode_done) dones++;
    end
    chk("rst_start.done_count", 16'(dones), 16'd0);

    chk("q1.drained", 16'(q1.size()), 16'd0);
    chk("q3.drained", 16'(q3.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
